// File: rtl/alu_wb_pkg.sv
// Shared constants and types for the ALU write-back router.
package alu_wb_pkg;

  // Destination codes carried alongside each ALU result
  localparam int unsigned DEST_NONE = 0;
  localparam int unsigned DEST_B    = 1;
  localparam int unsigned DEST_C    = 2;
  localparam int unsigned DEST_D    = 3;
  localparam int unsigned DEST_ACC  = 4;

  // One-hot register-file write enables, bit order {ACC,D,C,B}
  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_B    = 4'b0001;
  localparam logic [3:0] WE_C    = 4'b0010;
  localparam logic [3:0] WE_D    = 4'b0100;
  localparam logic [3:0] WE_ACC  = 4'b1000;

  // FIFO occupancy state
  typedef enum logic [1:0] {
    StEmpty,
    StActive,
    StFull
  } occ_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding {dest, data} entries for the write-back router.
// Caller guarantees push only when count < DEPTH and pop only when count > 0.
module wb_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage array; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/alu_wb_router.sv
// ALU write-back router: buffers tagged ALU results and issues one-hot register-file writes.
// Optional build macro: WB_FLAGS_EN adds zero/negative flags tracking the last issued write.
module alu_wb_router
  import alu_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEST_W = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [DEST_W-1:0] res_dest,
  input  logic              wb_stall,
  output logic [3:0]        wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              err_sticky,
  input  logic              err_clr,
  output logic              zero_flag,
  output logic              neg_flag
);

  localparam int unsigned EntW = DATA_W + DEST_W;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [CntW-1:0]   count;
  logic              push, pop;
  logic [EntW-1:0]   head;
  logic [DATA_W-1:0] head_data;
  logic [DEST_W-1:0] head_dest;
  logic [3:0]        dec_we;
  logic              dec_illegal;

  occ_state_e        state_q;
  logic [3:0]        wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              err_q;

  // No pop-through when full: ready depends only on occupancy
  assign res_ready = (count < CntW'(DEPTH));
  assign push      = res_valid && res_ready;
  assign pop       = (count != '0) && !wb_stall;
  assign head_data = head[DATA_W-1:0];
  assign head_dest = head[EntW-1:DATA_W];

  wb_fifo #(
    .WIDTH(EntW),
    .DEPTH(DEPTH),
    .CNT_W(CntW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({res_dest, res_data}),
    .pop      (pop),
    .pop_data (head),
    .count    (count)
  );

  // Decode the head entry's destination into a write enable or an error
  always_comb begin
    dec_we      = WE_NONE;
    dec_illegal = 1'b0;
    case (head_dest)
      DEST_W'(DEST_NONE): dec_we = WE_NONE;
      DEST_W'(DEST_B):    dec_we = WE_B;
      DEST_W'(DEST_C):    dec_we = WE_C;
      DEST_W'(DEST_D):    dec_we = WE_D;
      DEST_W'(DEST_ACC):  dec_we = WE_ACC;
      default:            dec_illegal = 1'b1;
    endcase
  end

  // Occupancy FSM tracking the FIFO fill level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (push) state_q <= StActive;
        StActive: begin
          if (push && !pop && count == CntW'(DEPTH - 1)) begin
            state_q <= StFull;
          end else if (pop && !push && count == CntW'(1)) begin
            state_q <= StEmpty;
          end
        end
        StFull: if (pop) state_q <= StActive;
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign busy = (state_q != StEmpty);

  // Registered write port; wr_data holds its value on idle edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= WE_NONE;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= pop ? dec_we : WE_NONE;
      if (pop) wr_data_q <= head_data;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;

  // Sticky error: an illegal pop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (pop && dec_illegal) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err_sticky = err_q;

`ifdef WB_FLAGS_EN
  logic zero_q, neg_q;

  // Flags follow only writes that actually reach the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (pop && (dec_we != WE_NONE)) begin
      zero_q <= (head_data == '0);
      neg_q  <= head_data[DATA_W-1];
    end
  end

  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
`else
  assign zero_flag = 1'b0;
  assign neg_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wb_router.sv
// Directed bench for alu_wb_router with hand-computed expectations.
module tb_alu_wb_router;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_dest;
  logic        wb_stall;
  logic [3:0]  wr_en;
  logic [15:0] wr_data;
  logic        busy;
  logic        err_sticky;
  logic        err_clr;
  logic        zero_flag;
  logic        neg_flag;

  int n_checks = 0;
  int n_fail   = 0;

  alu_wb_router #(
    .DATA_W(16),
    .DEST_W(3),
    .DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_dest  (res_dest),
    .wb_stall  (wb_stall),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .busy      (busy),
    .err_sticky(err_sticky),
    .err_clr   (err_clr),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_dest = '0;
    wb_stall = 1'b0; err_clr = 1'b0;
    #12;
    n_checks++;
    if (wr_en !== 4'b0000 || wr_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_wr: wr_en=%b wr_data=%h want 0000/0000", wr_en, wr_data);
    end
    n_checks++;
    if (busy !== 1'b0 || res_ready !== 1'b1 || err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b ready=%b err=%b want 0/1/0", busy, res_ready, err_sticky);
    end
    n_checks++;
    if (zero_flag !== 1'b0 || neg_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: zero=%b neg=%b want 0/0", zero_flag, neg_flag);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    res_valid = 1'b1; res_data = 16'h1234; res_dest = 3'd2;
    tick();  // accept edge
    res_valid = 1'b0;
    n_checks++;
    if (wr_en !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_early: wr_en=%b busy=%b want 0000/1", wr_en, busy);
    end
    tick();
    n_checks++;
    if (wr_en !== 4'b0010 || wr_data !== 16'h1234) begin
      n_fail++; $display("FAIL single_write: wr_en=%b wr_data=%h want 0010/1234", wr_en, wr_data);
    end
    tick();
    n_checks++;
    if (wr_en !== 4'b0000 || busy !== 1'b0 || wr_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_after: wr_en=%b busy=%b wr_data=%h want 0000/0/1234", wr_en, busy, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    res_valid = 1'b1; res_dest = 3'd1; res_data = 16'd1;
    tick();
    n_checks++;
    if (wr_en !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_0: wr_en=%b want 0000", wr_en);
    end
    res_dest = 3'd3; res_data = 16'd2;
    tick();
    n_checks++;
    if (wr_en !== 4'b0001 || wr_data !== 16'd1 || res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_1: wr_en=%b wr_data=%h ready=%b want 0001/0001/1", wr_en, wr_data, res_ready);
    end
    res_dest = 3'd4; res_data = 16'd3;
    tick();
    n_checks++;
    if (wr_en !== 4'b0100 || wr_data !== 16'd2) begin
      n_fail++; $display("FAIL b2b_2: wr_en=%b wr_data=%h want 0100/0002", wr_en, wr_data);
    end
    res_valid = 1'b0;
    tick();
    n_checks++;
    if (wr_en !== 4'b1000 || wr_data !== 16'd3) begin
      n_fail++; $display("FAIL b2b_3: wr_en=%b wr_data=%h want 1000/0003", wr_en, wr_data);
    end
    tick();
    n_checks++;
    if (wr_en !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: wr_en=%b busy=%b want 0000/0", wr_en, busy);
    end
  endtask

  task automatic test_stall();
    wb_stall = 1'b1;
    res_valid = 1'b1; res_dest = 3'd1; res_data = 16'hAAAA;
    tick();
    n_checks++;
    if (res_ready !== 1'b1 || wr_en !== 4'b0000) begin
      n_fail++; $display("FAIL stall_one: ready=%b wr_en=%b want 1/0000", res_ready, wr_en);
    end
    res_dest = 3'd2; res_data = 16'hBBBB;
    tick();
    n_checks++;
    if (res_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_full: ready=%b busy=%b want 0/1", res_ready, busy);
    end
    res_dest = 3'd3; res_data = 16'hCCCC;
    tick();  // third result must not be taken
    n_checks++;
    if (res_ready !== 1'b0 || wr_en !== 4'b0000) begin
      n_fail++; $display("FAIL stall_hold: ready=%b wr_en=%b want 0/0000", res_ready, wr_en);
    end
    wb_stall = 1'b0;
    tick();
    n_checks++;
    if (wr_en !== 4'b0001 || wr_data !== 16'hAAAA || res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_rel_a: wr_en=%b wr_data=%h ready=%b want 0001/aaaa/1", wr_en, wr_data, res_ready);
    end
    tick();  // third result accepted here
    res_valid = 1'b0;
    n_checks++;
    if (wr_en !== 4'b0010 || wr_data !== 16'hBBBB) begin
      n_fail++; $display("FAIL stall_rel_b: wr_en=%b wr_data=%h want 0010/bbbb", wr_en, wr_data);
    end
    tick();
    n_checks++;
    if (wr_en !== 4'b0100 || wr_data !== 16'hCCCC) begin
      n_fail++; $display("FAIL stall_rel_c: wr_en=%b wr_data=%h want 0100/cccc", wr_en, wr_data);
    end
    tick();
    n_checks++;
    if (wr_en !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: wr_en=%b busy=%b want 0000/0", wr_en, busy);
    end
  endtask

  task automatic test_discard_illegal();
    res_valid = 1'b1; res_dest = 3'd0; res_data = 16'h0005;
    tick();
    res_dest = 3'd6; res_data = 16'h0007;
    tick();  // dest 0 popped
    res_valid = 1'b0;
    n_checks++;
    if (wr_en !== 4'b0000 || err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL discard: wr_en=%b err=%b want 0000/0", wr_en, err_sticky);
    end
    tick();  // dest 6 popped
    n_checks++;
    if (wr_en !== 4'b0000 || err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL illegal: wr_en=%b err=%b want 0000/1", wr_en, err_sticky);
    end
    tick();
    n_checks++;
    if (err_sticky !== 1'b1) begin
      n_fail++; $display("FAIL err_hold: err=%b want 1", err_sticky);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL err_clr: err=%b want 0", err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    wb_stall = 1'b1;
    res_valid = 1'b1; res_dest = 3'd1; res_data = 16'h1111;
    tick();
    res_dest = 3'd2; res_data = 16'h2222;
    tick();
    res_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (wr_en !== 4'b0000 || wr_data !== 16'h0000 || busy !== 1'b0 || res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: wr_en=%b wr_data=%h busy=%b ready=%b want 0000/0000/0/1",
               wr_en, wr_data, busy, res_ready);
    end
    #2;
    rst_n = 1'b1;
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (wr_en !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL rst_after_%0d: wr_en=%b busy=%b want 0000/0", i, wr_en, busy);
      end
    end
  endtask

`ifdef WB_FLAGS_EN
  task automatic test_flags();
    res_valid = 1'b1; res_dest = 3'd1; res_data = 16'h0000;
    tick();
    res_dest = 3'd0; res_data = 16'h8001;
    tick();  // zero write issued
    res_dest = 3'd2; res_data = 16'h8001;
    n_checks++;
    if (zero_flag !== 1'b1 || neg_flag !== 1'b0) begin
      n_fail++; $display("FAIL flags_zero: zero=%b neg=%b want 1/0", zero_flag, neg_flag);
    end
    tick();  // discard popped
    res_valid = 1'b0;
    n_checks++;
    if (zero_flag !== 1'b1 || neg_flag !== 1'b0) begin
      n_fail++; $display("FAIL flags_discard: zero=%b neg=%b want 1/0", zero_flag, neg_flag);
    end
    tick();  // 8001 written to C
    n_checks++;
    if (zero_flag !== 1'b0 || neg_flag !== 1'b1 || wr_en !== 4'b0010) begin
      n_fail++;
      $display("FAIL flags_neg: zero=%b neg=%b wr_en=%b want 0/1/0010", zero_flag, neg_flag, wr_en);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_discard_illegal();
`ifdef WB_FLAGS_EN
    test_flags();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
